// File: rtl/accel_job_driver.sv
// Initiator side of an accelerator start/done handshake: gathers NOPS operands,
// issues one job at a time and queues each retired result in a small FIFO.
module accel_job_driver #(
    parameter int DW      = 16,
    parameter int NOPS    = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    input  logic               acc_op_ready,
    output logic               acc_start,
    output logic [NOPS*DW-1:0] acc_operands,
    input  logic               acc_result_en,
    input  logic [DW-1:0]      acc_result,
    input  logic               acc_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic               busy,
    output logic               err_timeout,
    output logic               err_noresult,
    output logic [7:0]         jobs_done
);
    localparam int CW = (NOPS > 1) ? $clog2(NOPS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_OP  = CW'(NOPS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   FIFO_CAP = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {LOAD, ISSUE, RUN, RETIRE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] ops [NOPS];
    logic [DW-1:0] hold;
    logic          seen;
    logic [TW-1:0] tmo;

    logic [DW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;

    logic          in_fire;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic [AW-1:0] wr_next;
    logic [AW-1:0] rd_next;
    logic [AW:0]   fifo_cnt_next;
    logic [DW-1:0] head_next;

    // Start is a decode of the ISSUE state so it can never fire while op_ready is low.
    assign in_ready  = rst && (state == LOAD);
    assign in_fire   = in_valid && in_ready;
    assign acc_start = rst && (state == ISSUE) && acc_op_ready && (fifo_cnt < FIFO_CAP);
    assign busy      = (state != LOAD) || (cnt != '0);

    for (genvar g = 0; g < NOPS; g++) begin : g_pack
        assign acc_operands[g*DW +: DW] = ops[g];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= LOAD;
            cnt          <= '0;
            hold         <= '0;
            seen         <= 1'b0;
            tmo          <= '0;
            err_timeout  <= 1'b0;
            err_noresult <= 1'b0;
            jobs_done    <= '0;
            for (int i = 0; i < NOPS; i++) begin
                ops[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        ops[cnt] <= in_data;
                        if (cnt == LAST_OP) begin
                            cnt   <= '0;
                            state <= ISSUE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (acc_start) begin
                        hold  <= '0;
                        seen  <= 1'b0;
                        tmo   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (acc_result_en) begin
                        hold <= acc_result;
                        seen <= 1'b1;
                    end
                    // A job that overstays its budget is dropped without a FIFO entry.
                    if (acc_done) begin
                        state <= RETIRE;
                    end else if (tmo == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= LOAD;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                RETIRE: begin
                    jobs_done <= jobs_done + 8'd1;
                    if (!seen) begin
                        err_noresult <= 1'b1;
                    end
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

    // ISSUE only proceeds with a free slot, so a push never meets a full FIFO.
    always_comb begin
        push          = (state == RETIRE);
        push_data     = seen ? hold : '0;
        pop           = out_ready && (fifo_cnt != '0);
        wr_next       = wr_ptr + AW'(push);
        rd_next       = rd_ptr + AW'(pop);
        fifo_cnt_next = fifo_cnt + (AW + 1)'(push) - (AW + 1)'(pop);
        head_next     = (push && (wr_ptr == rd_next)) ? push_data : fifo_mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // The head is registered from the post-update pointers so out_data tracks pushes into an empty FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            fifo_cnt  <= fifo_cnt_next;
            out_valid <= (fifo_cnt_next != '0);
            out_data  <= (fifo_cnt_next != '0) ? head_next : '0;
        end
    end

endmodule

// File: tb/tb_accel_job_driver.sv
// Directed bench for accel_job_driver: each cycle drives inputs at posedge+1
// and compares outputs at posedge+2 against hand-computed values.
module tb_accel_job_driver;
    localparam int DW      = 16;
    localparam int NOPS    = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_data;
    logic               acc_op_ready;
    logic               acc_start;
    logic [NOPS*DW-1:0] acc_operands;
    logic               acc_result_en;
    logic [DW-1:0]      acc_result;
    logic               acc_done;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic               busy;
    logic               err_timeout;
    logic               err_noresult;
    logic [7:0]         jobs_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accel_job_driver #(
        .DW(DW), .NOPS(NOPS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .acc_op_ready(acc_op_ready), .acc_start(acc_start), .acc_operands(acc_operands),
        .acc_result_en(acc_result_en), .acc_result(acc_result), .acc_done(acc_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_timeout(err_timeout), .err_noresult(err_noresult),
        .jobs_done(jobs_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic opr,
                                 input logic ren, input logic [DW-1:0] r, input logic dn,
                                 input logic ordy);
        in_valid      = v;
        in_data       = d;
        acc_op_ready  = opr;
        acc_result_en = ren;
        acc_result    = r;
        acc_done      = dn;
        out_ready     = ordy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic loadOps(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [DW-1:0] ops [4];
        ops = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, ops[i], 1'b0, 1'b0, '0, 1'b0, 1'b0);
            checkOutput("load_in_ready", in_ready, 1);
            tick();
        end
    endtask

    // Loads a job, issues it immediately, finishes with same-cycle result+done; returns in the next LOAD cycle.
    task automatic quickJob(input logic [DW-1:0] res);
        loadOps(res, res + 16'd1, res + 16'd2, res + 16'd3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("quick_start", acc_start, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, res, 1'b1, 1'b0);
        tick();
        idle();
        tick();
    endtask

    initial begin
        logic [DW-1:0] exp_q [4];

        $display("[TB] start");
        rst = 1'b0;
        idle();
        tick();
        idle();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_acc_start", acc_start, 0);
        checkOutput("rst_operands", acc_operands, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_timeout", err_timeout, 0);
        checkOutput("rst_err_noresult", err_noresult, 0);
        checkOutput("rst_jobs_done", jobs_done, 0);
        rst = 1'b1;
        idle();
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Job 1: 3,5,7,2 against the 4-cycle schedule, result 0x002C
        $display("[TB] basic job");
        loadOps(16'd3, 16'd5, 16'd7, 16'd2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("j1_start", acc_start, 1);
        checkOutput("j1_in_ready", in_ready, 0);
        checkOutput("j1_busy", busy, 1);
        checkOutput("j1_operands", acc_operands, 64'h0002_0007_0005_0003);
        tick();
        idle();
        checkOutput("j1_start_once", acc_start, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle();
        end
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h002C, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("j1_operands_held", acc_operands, 64'h0002_0007_0005_0003);
        tick();
        idle();
        checkOutput("j1_retire_out_valid", out_valid, 0);
        checkOutput("j1_retire_busy", busy, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("j1_out_valid", out_valid, 1);
        checkOutput("j1_out_data", out_data, 16'h002C);
        checkOutput("j1_jobs_done", jobs_done, 1);
        checkOutput("j1_in_ready", in_ready, 1);
        checkOutput("j1_busy_idle", busy, 0);
        checkOutput("j1_err_noresult", err_noresult, 0);
        tick();
        idle();
        checkOutput("j1_popped", out_valid, 0);

        // Job 2: op_ready held low 10 cycles, then same-cycle result+done 0x1234
        $display("[TB] op_ready stall and same-cycle result");
        loadOps(16'd1, 16'd2, 16'd3, 16'd4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            checkOutput("stall_start", acc_start, 0);
            checkOutput("stall_in_ready", in_ready, 0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("j2_start", acc_start, 1);
        checkOutput("j2_operands", acc_operands, 64'h0004_0003_0002_0001);
        tick();
        idle();
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("j2_out_valid", out_valid, 1);
        checkOutput("j2_out_data", out_data, 16'h1234);
        checkOutput("j2_jobs_done", jobs_done, 2);
        checkOutput("j2_err_noresult", err_noresult, 0);
        tick();

        // Job 3: done with no result_en pushes zero and flags it
        $display("[TB] missing result");
        loadOps(16'h10, 16'h11, 16'h12, 16'h13);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("j3_start", acc_start, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("j3_out_valid", out_valid, 1);
        checkOutput("j3_out_data", out_data, 16'h0000);
        checkOutput("j3_err_noresult", err_noresult, 1);
        checkOutput("j3_jobs_done", jobs_done, 3);
        tick();
        idle();
        checkOutput("j3_popped", out_valid, 0);

        // Five jobs with no consumer: the fifth waits for a free slot
        $display("[TB] backpressure");
        quickJob(16'h00A0);
        quickJob(16'h00A1);
        quickJob(16'h00A2);
        quickJob(16'h00A3);
        loadOps(16'h00A4, 16'h00A5, 16'h00A6, 16'h00A7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            checkOutput("full_no_start", acc_start, 0);
            checkOutput("full_out_valid", out_valid, 1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("pop_cycle_no_start", acc_start, 0);
        checkOutput("bp_head0", out_data, 16'h00A0);
        checkOutput("bp_jobs_done4", jobs_done, 7);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("bp_fifth_start", acc_start, 1);
        checkOutput("bp_head1", out_data, 16'h00A1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h00A4, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        exp_q = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
            checkOutput("bp_order_valid", out_valid, 1);
            checkOutput("bp_order_data", out_data, exp_q[i]);
            tick();
        end
        idle();
        checkOutput("bp_drained", out_valid, 0);
        checkOutput("bp_jobs_done", jobs_done, 8);

        // Accelerator never finishes: abandoned after 64 RUN cycles
        $display("[TB] timeout");
        loadOps(16'h20, 16'h21, 16'h22, 16'h23);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("to_start", acc_start, 1);
        tick();
        idle();
        for (int i = 0; i < 63; i++) begin
            tick();
            idle();
        end
        checkOutput("to_last_run_err", err_timeout, 0);
        checkOutput("to_last_run_in_ready", in_ready, 0);
        tick();
        idle();
        checkOutput("to_err", err_timeout, 1);
        checkOutput("to_in_ready", in_ready, 1);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_no_push", out_valid, 0);
        checkOutput("to_jobs_done", jobs_done, 8);

        // Reset pulled mid-RUN clears everything; the next job still works
        $display("[TB] reset during run");
        quickJob(16'h55AA);
        idle();
        checkOutput("pre_rst_out_valid", out_valid, 1);
        checkOutput("pre_rst_out_data", out_data, 16'h55AA);
        checkOutput("pre_rst_jobs_done", jobs_done, 9);
        checkOutput("sticky_timeout", err_timeout, 1);
        checkOutput("sticky_noresult", err_noresult, 1);
        loadOps(16'h30, 16'h31, 16'h32, 16'h33);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        checkOutput("mid_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b1;
        idle();
        checkOutput("after_rst_out_valid", out_valid, 0);
        checkOutput("after_rst_jobs_done", jobs_done, 0);
        checkOutput("after_rst_in_ready", in_ready, 1);
        checkOutput("after_rst_busy", busy, 0);
        checkOutput("after_rst_err_timeout", err_timeout, 0);
        checkOutput("after_rst_err_noresult", err_noresult, 0);
        checkOutput("after_rst_operands", acc_operands, 0);

        loadOps(16'd9, 16'd8, 16'd7, 16'd6);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("final_start", acc_start, 1);
        checkOutput("final_operands", acc_operands, 64'h0006_0007_0008_0009);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
        end
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h0BEE, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("final_s7_out_valid", out_valid, 0);
        tick();
        idle();
        checkOutput("final_s8_out_valid", out_valid, 1);
        checkOutput("final_out_data", out_data, 16'h0BEE);
        checkOutput("final_jobs_done", jobs_done, 1);
        checkOutput("final_err_noresult", err_noresult, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
